fc_layer_ctrl: RTL and testbench

Sequencer for one fully-connected layer. It accepts one input vector of PREVIOUS_LAYER_HEIGHT words from the upstream layer over a valid/ready handshake. It drives the shared control bus (mem_addr, sum_en, add_bias, data) to every neuron of the layer, then presents "layer result valid" downstream and holds it until acknowledged. This block is the initiator side of the neuron control interface.

---
 rtl/fc_layer_ctrl.sv | 139 +++++++++++++
 tb/tb_fc_layer_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: sequencer for one fully-connected layer.
// Collects one input vector of PREVIOUS_LAYER_HEIGHT words from upstream and
// broadcasts each word with its weight address to the neurons. It then runs a
// bias/load step and holds "layer result valid" until downstream consumes it.
// Optional feature macro: FC_LAYER_CTRL_PERF_EN adds vec_count_o, a wrapping
// count of consumed layer results.
//
// state  | meaning
// ACCEPT | take input words over valid/ready, mem_addr_o = word index
// BIAS   | last word accumulates in the neurons, mem_addr_o = bias address
// LOAD   | add_bias_o high, neurons register their result
// DONE   | valid_o high until ready_i, mem_addr_o prefetches word 0

module fc_layer_ctrl #(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    localparam int ADDR_BITS            = $clog2(PREVIOUS_LAYER_HEIGHT + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [WORD_SIZE-1:0] data_i,
    output logic signed [WORD_SIZE-1:0] data_o,
    output logic [ADDR_BITS-1:0]        mem_addr_o,
    output logic                        sum_en_o,
    output logic                        add_bias_o,
    output logic                        valid_o,
    input  logic                        ready_i
`ifdef FC_LAYER_CTRL_PERF_EN
    ,
    output logic [15:0]                 vec_count_o
`endif
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(PREVIOUS_LAYER_HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] BIAS_ADDR = ADDR_BITS'(PREVIOUS_LAYER_HEIGHT);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        BIAS   = 2'd1,
        LOAD   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                      state, state_next;
    logic [ADDR_BITS-1:0]        cnt, cnt_next;
    logic signed [WORD_SIZE-1:0] data_next;
    logic                        sum_en_next;
    logic                        add_bias_next;
    logic                        valid_next;

    // State register plus the registered control bus; reset dominates everything.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ACCEPT;
            cnt        <= '0;
            data_o     <= '0;
            sum_en_o   <= 1'b0;
            add_bias_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            data_o     <= data_next;
            sum_en_o   <= sum_en_next;
            add_bias_o <= add_bias_next;
            valid_o    <= valid_next;
        end
    end

    // Next-state and next values of the registered outputs.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        data_next     = data_o;
        sum_en_next   = 1'b0;
        add_bias_next = 1'b0;
        valid_next    = 1'b0;
        unique case (state)
            ACCEPT: begin
                if (valid_i) begin
                    data_next   = data_i;
                    sum_en_next = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_next   = '0;
                        state_next = BIAS;
                    end else begin
                        cnt_next = cnt + ADDR_BITS'(1);
                    end
                end
            end
            BIAS: begin
                add_bias_next = 1'b1;
                state_next    = LOAD;
            end
            LOAD: begin
                valid_next = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                // A consume on the first valid cycle is honoured immediately.
                if (ready_i) begin
                    state_next = ACCEPT;
                end else begin
                    valid_next = 1'b1;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    // Combinational handshake and address outputs decoded from state/cnt.
    always_comb begin
        ready_o    = 1'b0;
        mem_addr_o = '0;
        unique case (state)
            ACCEPT: begin
                ready_o    = 1'b1;
                mem_addr_o = cnt;
            end
            BIAS, LOAD: mem_addr_o = BIAS_ADDR;
            DONE:       mem_addr_o = '0;
            default:    mem_addr_o = '0;
        endcase
    end

`ifdef FC_LAYER_CTRL_PERF_EN
    // Count consumed layer results; wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vec_count_o <= '0;
        end else if (state == DONE && ready_i) begin
            vec_count_o <= vec_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl (H=4, 16-bit words).
module tb_fc_layer_ctrl;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               valid_i;
    logic               ready_o;
    logic signed [15:0] data_i;
    logic signed [15:0] data_o;
    logic [2:0]         mem_addr_o;
    logic               sum_en_o;
    logic               add_bias_o;
    logic               valid_o;
    logic               ready_i;
`ifdef FC_LAYER_CTRL_PERF_EN
    logic [15:0]        vec_count_o;
`endif

    int tests  = 0;
    int failed = 0;

    fc_layer_ctrl #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .data_o     (data_o),
        .mem_addr_o (mem_addr_o),
        .sum_en_o   (sum_en_o),
        .add_bias_o (add_bias_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
`ifdef FC_LAYER_CTRL_PERF_EN
        ,
        .vec_count_o(vec_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic signed [15:0] w[4];
    logic signed [15:0] g[4];
    int rise[$];

    initial begin
        w[0] = 16'sd3;  w[1] = -16'sd2; w[2] = 16'sd7;      w[3] = 16'sd1;
        g[0] = 16'sd5;  g[1] = -16'sd8; g[2] = 16'sh7FFF;   g[3] = 16'sh8000;
        reset_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        chk("rst_valid",    32'(valid_o), 0);
        chk("rst_sum_en",   32'(sum_en_o), 0);
        chk("rst_add_bias", 32'(add_bias_o), 0);
        chk("rst_data",     32'(data_o), 0);
        chk("rst_ready",    32'(ready_o), 1);
        chk("rst_addr",     32'(mem_addr_o), 0);

        // Back-to-back vector 3,-2,7,1
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = w[i];
            chk("b2b_addr",  32'(mem_addr_o), 32'(i));
            chk("b2b_ready", 32'(ready_o), 1);
            step();
            chk("b2b_sum_en", 32'(sum_en_o), 1);
            chk("b2b_data",   32'(data_o), 32'(w[i]));
        end
        valid_i = 1'b0;
        chk("bias_addr",     32'(mem_addr_o), 4);
        chk("bias_ready",    32'(ready_o), 0);
        chk("bias_addbias",  32'(add_bias_o), 0);
        step();
        chk("load_addbias",  32'(add_bias_o), 1);
        chk("load_sum_en",   32'(sum_en_o), 0);
        chk("load_addr",     32'(mem_addr_o), 4);
        chk("load_valid",    32'(valid_o), 0);
        step();
        chk("done_valid",    32'(valid_o), 1);
        chk("done_addbias",  32'(add_bias_o), 0);
        chk("done_addr",     32'(mem_addr_o), 0);

        // DONE held 5 cycles with ready_i low while upstream offers a word
        valid_i = 1'b1; data_i = 16'sd99; ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid",  32'(valid_o), 1);
            chk("hold_ready",  32'(ready_o), 0);
            chk("hold_sum_en", 32'(sum_en_o), 0);
            step();
        end
        ready_i = 1'b1;
        chk("hold_valid6", 32'(valid_o), 1);
        step();
        valid_i = 1'b0; ready_i = 1'b0;
        chk("resume_valid",  32'(valid_o), 0);
        chk("resume_ready",  32'(ready_o), 1);
        chk("resume_addr",   32'(mem_addr_o), 0);
        chk("resume_data",   32'(data_o), 32'(w[3]));
        chk("resume_sum_en", 32'(sum_en_o), 0);

        // Gapped input: two idle cycles between words
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = g[i];
            chk("gap_addr_hs", 32'(mem_addr_o), 32'(i));
            step();
            valid_i = 1'b0;
            chk("gap_sum_en", 32'(sum_en_o), 1);
            chk("gap_data",   32'(data_o), 32'(g[i]));
            if (i < 3) begin
                chk("gap_addr_a", 32'(mem_addr_o), 32'(i + 1));
                step();
                chk("gap_idle_a", 32'(sum_en_o), 0);
                chk("gap_addr_b", 32'(mem_addr_o), 32'(i + 1));
                step();
                chk("gap_idle_b", 32'(sum_en_o), 0);
                chk("gap_hold_d", 32'(data_o), 32'(g[i]));
            end
        end
        chk("gap_bias_addr", 32'(mem_addr_o), 4);
        step();
        chk("gap_addbias", 32'(add_bias_o), 1);
        step();
        chk("gap_valid", 32'(valid_o), 1);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("gap_consumed", 32'(valid_o), 0);

        // Reset in the cycle after word 2 is accepted
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; data_i = w[i];
            step();
        end
        reset_i = 1'b1; data_i = 16'sd42;
        step();
        reset_i = 1'b0; valid_i = 1'b0;
        chk("mid_rst_sum_en", 32'(sum_en_o), 0);
        chk("mid_rst_data",   32'(data_o), 0);
        chk("mid_rst_addr",   32'(mem_addr_o), 0);
        chk("mid_rst_valid",  32'(valid_o), 0);
        chk("mid_rst_addb",   32'(add_bias_o), 0);
        chk("mid_rst_ready",  32'(ready_o), 1);
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = g[3 - i];
            chk("fresh_addr", 32'(mem_addr_o), 32'(i));
            step();
            chk("fresh_data", 32'(data_o), 32'(g[3 - i]));
        end
        valid_i = 1'b0;
        chk("fresh_bias_addr", 32'(mem_addr_o), 4);
        step();
        chk("fresh_addbias", 32'(add_bias_o), 1);
        chk("fresh_valid_t2", 32'(valid_o), 0);
        step();
        chk("fresh_valid_t3", 32'(valid_o), 1);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;

        // Clean reset, then three vectors with ready_i held high
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
`ifdef FC_LAYER_CTRL_PERF_EN
        chk("perf_reset", 32'(vec_count_o), 0);
`endif
        ready_i = 1'b1; valid_i = 1'b1;
        for (int c = 0; c < 60 && rise.size() < 3; c++) begin
            data_i = 16'(c);
            step();
            if (valid_o) rise.push_back(c);
        end
        valid_i = 1'b0;
        chk("b2b3_vectors", 32'(rise.size()), 3);
        if (rise.size() == 3) begin
            chk("b2b3_period1", 32'(rise[1] - rise[0]), 7);
            chk("b2b3_period2", 32'(rise[2] - rise[1]), 7);
        end
        step();
        chk("b2b3_consumed", 32'(valid_o), 0);
        chk("b2b3_ready",    32'(ready_o), 1);
`ifdef FC_LAYER_CTRL_PERF_EN
        chk("perf_count3", 32'(vec_count_o), 3);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("perf_reset2", 32'(vec_count_o), 0);
`endif
        ready_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
